irq_encoder_32to5: RTL and testbench

IRQ_ENCODER_32TO5 -- requirements
Module: irq_encoder_32to5

---
 rtl/irq_encoder_32to5_pkg.sv | 19 +
 rtl/irq_encoder_32to5_pick.sv | 30 +++
 rtl/irq_encoder_32to5.sv | 111 +++++++++++
 tb/tb_irq_encoder_32to5.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_encoder_32to5_pkg.sv
// ---------------------------------------------------------------------------
// irq_encoder_32to5_pkg
//
// Shared definitions for the 32-to-5 interrupt encoder: the request vector
// width, the index width and the two-state presentation FSM encoding.
// No ports; imported by irq_encoder_32to5 and priority_pick_32.
// ---------------------------------------------------------------------------
package irq_encoder_32to5_pkg;

    localparam int N_REQ = 32;
    localparam int IDX_W = 5;

    // IDLE: nothing offered to the consumer; PRESENT: o_index is being offered
    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/irq_encoder_32to5_pick.sv
// ---------------------------------------------------------------------------
// priority_pick_32
//
// Purely combinational lowest-index-first picker.
//   vec  in   N_REQ  candidate bits
//   idx  out  IDX_W  index of the lowest set bit of vec (0 when vec is zero)
//   any  out  1      high when at least one bit of vec is set
// ---------------------------------------------------------------------------
module priority_pick_32
    import irq_encoder_32to5_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top down so the last hit, which is the lowest set bit,
    // is the one that sticks.
    always_comb begin
        idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/irq_encoder_32to5.sv
// ---------------------------------------------------------------------------
// irq_encoder_32to5
//
// Collects 32 interrupt request lines into a sticky pending register and
// offers one selected source at a time through a valid/ready handshake.
//   PRIORITY_MODE  0 = fixed lowest-index-first, 1 = round-robin
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_req   [31:0] request lines, each high cycle marks the source pending
//   i_mask  [31:0] excludes sources from selection, pending bits kept
//   i_clear        synchronous clear of pending state and the output slot
//   i_ready        consumer accepts o_index when o_valid is also high
//   o_valid        o_index holds a selection awaiting acceptance
//   o_index  [4:0] selected source
//   o_pending[31:0] pending register, straight from flops
// ---------------------------------------------------------------------------
module irq_encoder_32to5
    import irq_encoder_32to5_pkg::*;
#(
    parameter bit PRIORITY_MODE = 1'b0
)
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_mask,
    input  logic             i_clear,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_index,
    output logic [N_REQ-1:0] o_pending
);

    state_t           state;
    logic [N_REQ-1:0] pending;
    logic [IDX_W-1:0] index;
    logic [IDX_W-1:0] rr_ptr;

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] rotated;
    logic [N_REQ-1:0] pick_vec;
    logic [N_REQ-1:0] accept_clear;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] pick_base;
    logic [IDX_W-1:0] selected;
    logic             pick_any;
    logic             handshake;

    assign eligible = pending & ~i_mask;

    // Rotate so that bit rr_ptr lands at position 0; the 5-bit index sum
    // wraps naturally, which gives the 31 -> 0 search order for free.
    always_comb begin
        rotated = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rotated[i] = eligible[IDX_W'(i) + rr_ptr];
        end
    end

    assign pick_vec  = PRIORITY_MODE ? rotated : eligible;
    assign pick_base = PRIORITY_MODE ? rr_ptr  : '0;

    priority_pick_32 u_pick (
        .vec (pick_vec),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Undo the rotation: the picker's index is relative to rr_ptr.
    assign selected  = pick_idx + pick_base;

    assign handshake    = (state == PRESENT) && i_ready;
    assign accept_clear = handshake ? (N_REQ'(1) << index) : '0;

    // Pending register, presentation FSM and round-robin pointer.
    // Clear beats a simultaneous handshake, and new requests always win over
    // both clear and acceptance so no edge on i_req is ever lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            pending <= '0;
            index   <= '0;
            rr_ptr  <= '0;
        end else if (i_clear) begin
            state   <= IDLE;
            pending <= i_req;
        end else begin
            pending <= (pending & ~accept_clear) | i_req;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        index <= selected;
                        state <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (i_ready) begin
                        state  <= IDLE;
                        rr_ptr <= index + IDX_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_valid   = (state == PRESENT);
    assign o_index   = index;
    assign o_pending = pending;

endmodule

// File: tb/tb_irq_encoder_32to5.sv
// ---------------------------------------------------------------------------
// tb_irq_encoder_32to5
//
// Drives one fixed-priority and one round-robin instance from the same
// inputs. A cycle-level model of the pending set / offer / accept behaviour
// is compared with both instances on every falling edge, and directed
// scenarios pin exact index sequences with literal expectations.
// ---------------------------------------------------------------------------
module tb_irq_encoder_32to5;

    logic        i_clk   = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_clear = 1'b0;
    logic        i_ready = 1'b0;
    logic [31:0] i_req   = '0;
    logic [31:0] i_mask  = '0;

    logic        valid0, valid1;
    logic [4:0]  index0, index1;
    logic [31:0] pending0, pending1;

    int errors = 0;
    int checks = 0;
    bit model_on = 1'b0;

    // Model state, slot 0 = fixed priority, slot 1 = round-robin
    bit [31:0] m_pend  [2];
    bit        m_valid [2];
    int        m_idx   [2];
    int        m_rr    [2];

    always #5 i_clk = ~i_clk;

    irq_encoder_32to5 #(.PRIORITY_MODE(1'b0)) dut_fixed (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (i_req),
        .i_mask    (i_mask),
        .i_clear   (i_clear),
        .i_ready   (i_ready),
        .o_valid   (valid0),
        .o_index   (index0),
        .o_pending (pending0)
    );

    irq_encoder_32to5 #(.PRIORITY_MODE(1'b1)) dut_rr (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (i_req),
        .i_mask    (i_mask),
        .i_clear   (i_clear),
        .i_ready   (i_ready),
        .o_valid   (valid1),
        .o_index   (index1),
        .o_pending (pending1)
    );

    // One clock of model behaviour for slot m, using the inputs seen at the edge
    task automatic modelStep(input int m);
        bit [31:0] elig;
        bit [31:0] next_pend;
        int        start;
        next_pend = m_pend[m] | i_req;
        if (i_clear) begin
            m_pend[m]  = i_req;
            m_valid[m] = 1'b0;
        end else if (m_valid[m] && i_ready) begin
            if (!i_req[m_idx[m]]) next_pend[m_idx[m]] = 1'b0;
            m_rr[m]    = (m_idx[m] + 1) % 32;
            m_valid[m] = 1'b0;
            m_pend[m]  = next_pend;
        end else begin
            if (!m_valid[m]) begin
                elig  = m_pend[m] & ~i_mask;
                start = (m == 1) ? m_rr[m] : 0;
                for (int k = 0; k < 32; k++) begin
                    if (!m_valid[m] && elig[(start + k) % 32]) begin
                        m_idx[m]   = (start + k) % 32;
                        m_valid[m] = 1'b1;
                    end
                end
            end
            m_pend[m] = next_pend;
        end
    endtask

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            m_pend[m]  = '0;
            m_valid[m] = 1'b0;
            m_idx[m]   = 0;
            m_rr[m]    = 0;
        end
    endtask

    // Model follows the DUT clock and the asynchronous reset
    always @(negedge i_rst_n) modelReset();

    always @(posedge i_clk) begin
        if (i_rst_n) begin
            modelStep(0);
            modelStep(1);
        end
    end

    task automatic compareOne(input string tag, input int m, input logic v,
                              input logic [4:0] idx, input logic [31:0] pend);
        checks++;
        if (v !== m_valid[m]) begin
            errors++;
            $display("[TB] FAIL model %s valid: got %0b, expected %0b", tag, v, m_valid[m]);
        end
        checks++;
        if (pend !== m_pend[m]) begin
            errors++;
            $display("[TB] FAIL model %s pending: got %08h, expected %08h", tag, pend, m_pend[m]);
        end
        if (m_valid[m]) begin
            checks++;
            if (idx !== 5'(m_idx[m])) begin
                errors++;
                $display("[TB] FAIL model %s index: got %0d, expected %0d", tag, idx, m_idx[m]);
            end
        end
    endtask

    // Single compare process against the model, away from the active edge
    always @(negedge i_clk) begin
        if (model_on) begin
            compareOne("fixed", 0, valid0, index0, pending0);
            compareOne("rr", 1, valid1, index1, pending1);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic expectValid(input string name, input int m, input logic v_exp,
                               input int idx_exp);
        string tag;
        tag = (m != 0) ? {name, " rr"} : {name, " fixed"};
        checkOutput({tag, " valid"}, 32'((m != 0) ? valid1 : valid0), 32'(v_exp));
        if (v_exp) begin
            checkOutput({tag, " index"}, 32'((m != 0) ? index1 : index0), 32'(idx_exp));
        end
    endtask

    task automatic expectPending(input string name, input int m, input logic [31:0] p_exp);
        string tag;
        tag = (m != 0) ? {name, " rr pending"} : {name, " fixed pending"};
        checkOutput(tag, (m != 0) ? pending1 : pending0, p_exp);
    endtask

    // Set inputs just after an edge, then advance to just after the next edge
    task automatic applyStimulus(input logic [31:0] req, input logic [31:0] mask,
                                 input logic ready, input logic clear);
        i_req   = req;
        i_mask  = mask;
        i_ready = ready;
        i_clear = clear;
        @(posedge i_clk);
        #2;
    endtask

    initial begin
        int seq_exp[3];
        seq_exp[0] = 2;
        seq_exp[1] = 4;
        seq_exp[2] = 31;

        #1 i_rst_n = 1'b0;
        #11 i_rst_n = 1'b1;
        model_on = 1'b1;
        for (int m = 0; m < 2; m++) begin
            expectValid("reset", m, 1'b0, 0);
            checkOutput("reset index", 32'((m != 0) ? index1 : index0), 32'd0);
            expectPending("reset", m, 32'h0);
        end
        @(posedge i_clk);
        #2;

        // Single request, two-cycle latency, pending drained by the handshake
        applyStimulus(32'h0000_0001, '0, 1'b1, 1'b0);
        expectPending("single set", 0, 32'h1);
        expectValid("single c+1", 0, 1'b0, 0);
        applyStimulus('0, '0, 1'b1, 1'b0);
        expectValid("single c+2", 0, 1'b1, 0);
        expectValid("single c+2", 1, 1'b1, 0);
        applyStimulus('0, '0, 1'b1, 1'b0);
        expectValid("single after", 0, 1'b0, 0);
        expectPending("single after", 0, 32'h0);

        // Three simultaneous sources served in order with bubbles between
        applyStimulus(32'h8000_0014, '0, 1'b1, 1'b0);
        expectPending("burst set", 0, 32'h8000_0014);
        for (int i = 0; i < 3; i++) begin
            applyStimulus('0, '0, 1'b1, 1'b0);
            expectValid("burst offer", 0, 1'b1, seq_exp[i]);
            expectValid("burst offer", 1, 1'b1, seq_exp[i]);
            applyStimulus('0, '0, 1'b1, 1'b0);
            expectValid("burst bubble", 0, 1'b0, 0);
            expectValid("burst bubble", 1, 1'b0, 0);
        end
        expectPending("burst drained", 1, 32'h0);

        // Held requests at both ends: round-robin alternates and wraps,
        // fixed priority keeps re-serving source 0 (set wins on accept)
        applyStimulus(32'h8000_0001, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h8000_0001, '0, 1'b1, 1'b0);
            expectValid("held offer", 1, 1'b1, (i % 2 == 0) ? 0 : 31);
            expectValid("held offer", 0, 1'b1, 0);
            if (i < 3) begin
                applyStimulus(32'h8000_0001, '0, 1'b1, 1'b0);
                expectPending("held set wins", 0, 32'h8000_0001);
            end
        end
        for (int i = 0; i < 4; i++) applyStimulus('0, '0, 1'b1, 1'b0);
        expectPending("held drained", 0, 32'h0);
        expectPending("held drained", 1, 32'h0);

        // Masked source skipped; mask change while presenting has no effect
        applyStimulus(32'h0000_0003, 32'h0000_0001, 1'b0, 1'b0);
        applyStimulus('0, 32'h0000_0001, 1'b0, 1'b0);
        expectValid("mask pick", 0, 1'b1, 1);
        expectValid("mask pick", 1, 1'b1, 1);
        applyStimulus('0, 32'h0000_0002, 1'b0, 1'b0);
        expectValid("mask hold", 0, 1'b1, 1);
        expectValid("mask hold", 1, 1'b1, 1);
        applyStimulus('0, 32'h0000_0002, 1'b0, 1'b0);
        expectValid("mask hold2", 1, 1'b1, 1);
        for (int i = 0; i < 3; i++) applyStimulus('0, '0, 1'b1, 1'b0);
        expectPending("mask drained", 1, 32'h0);

        // Clear beats a handshake; set wins over clear; rr pointer untouched
        applyStimulus(32'h0000_0020, '0, 1'b0, 1'b0);
        applyStimulus('0, '0, 1'b0, 1'b0);
        expectValid("clear pre", 0, 1'b1, 5);
        expectValid("clear pre", 1, 1'b1, 5);
        applyStimulus(32'h0000_0100, 32'hFFFF_FFFF, 1'b1, 1'b1);
        expectValid("clear", 1, 1'b0, 0);
        expectPending("clear", 0, 32'h0000_0100);
        expectPending("clear", 1, 32'h0000_0100);
        applyStimulus(32'h0000_0004, 32'hFFFF_FFFF, 1'b0, 1'b0);
        expectValid("all masked", 0, 1'b0, 0);
        applyStimulus('0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        expectValid("all masked", 1, 1'b0, 0);
        expectPending("all masked", 1, 32'h0000_0104);
        applyStimulus('0, '0, 1'b0, 1'b0);
        expectValid("rr unchanged", 1, 1'b1, 2);
        expectValid("rr unchanged", 0, 1'b1, 2);
        for (int i = 0; i < 3; i++) applyStimulus('0, '0, 1'b1, 1'b0);
        expectPending("clear drained", 1, 32'h0);

        // Asynchronous reset while presenting
        applyStimulus(32'h0000_0400, '0, 1'b0, 1'b0);
        applyStimulus('0, '0, 1'b0, 1'b0);
        expectValid("rst pre", 0, 1'b1, 10);
        i_ready = 1'b1;
        #1 i_rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            expectValid("async rst", m, 1'b0, 0);
            checkOutput("async rst index", 32'((m != 0) ? index1 : index0), 32'd0);
            expectPending("async rst", m, 32'h0);
        end
        #4 i_rst_n = 1'b1;
        applyStimulus('0, '0, 1'b1, 1'b0);
        expectValid("post rst", 0, 1'b0, 0);
        expectValid("post rst", 1, 1'b0, 0);
        applyStimulus('0, '0, 1'b1, 1'b0);
        expectPending("post rst", 1, 32'h0);

        @(negedge i_clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
